// File: rtl/ps2_key_pkg.sv
// ----------------------------------------------------------------------------
// ps2_key_pkg : scan codes, key/state enums and decode helpers.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ps2_key_pkg;

  localparam logic [7:0] c_SC_UP    = 8'h75;
  localparam logic [7:0] c_SC_DOWN  = 8'h72;
  localparam logic [7:0] c_SC_LEFT  = 8'h6b;
  localparam logic [7:0] c_SC_RIGHT = 8'h74;
  localparam logic [7:0] c_SC_ENTER = 8'h5a;
  localparam logic [7:0] c_SC_SPACE = 8'h29;
  localparam logic [7:0] c_SC_BREAK = 8'hf0;

  typedef enum logic [2:0] {
    KEY_NONE  = 3'd0,
    KEY_UP    = 3'd1,
    KEY_DOWN  = 3'd2,
    KEY_LEFT  = 3'd3,
    KEY_RIGHT = 3'd4,
    KEY_ENTER = 3'd5,
    KEY_SPACE = 3'd6
  } key_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRESS  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_REPEAT = 2'd3
  } state_t;

  function automatic key_t decode_key(input logic [7:0] code);
    case (code)
      c_SC_UP:    return KEY_UP;
      c_SC_DOWN:  return KEY_DOWN;
      c_SC_LEFT:  return KEY_LEFT;
      c_SC_RIGHT: return KEY_RIGHT;
      c_SC_ENTER: return KEY_ENTER;
      c_SC_SPACE: return KEY_SPACE;
      default:    return KEY_NONE;
    endcase
  endfunction

  // Pulse vector order: {up, down, left, right, enter, space}
  function automatic logic [5:0] key_onehot(input key_t key);
    case (key)
      KEY_UP:    return 6'b100000;
      KEY_DOWN:  return 6'b010000;
      KEY_LEFT:  return 6'b001000;
      KEY_RIGHT: return 6'b000100;
      KEY_ENTER: return 6'b000010;
      KEY_SPACE: return 6'b000001;
      default:   return 6'b000000;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_code_sync.sv
// ----------------------------------------------------------------------------
// ps2_code_sync : 2-FF synchronizer plus stability filter for the key code.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ps2_code_sync #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_code,
  output logic [7:0] o_code
);

  localparam int                 c_CNT_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STABLE_CYCLES - 1);

  logic [7:0]         r_meta;
  logic [7:0]         r_sync;
  logic [7:0]         r_code;
  logic [c_CNT_W-1:0] r_stab_cnt;
  logic               w_same;

  // The value about to enter r_sync equals the current one: sync code unchanged this edge.
  assign w_same = (r_meta == r_sync);
  assign o_code = r_code;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta     <= '0;
      r_sync     <= '0;
      r_code     <= '0;
      r_stab_cnt <= '0;
    end else begin
      r_meta <= i_code;
      r_sync <= r_meta;
      if (!w_same) begin
        r_stab_cnt <= '0;
      end else if (r_stab_cnt != c_CNT_MAX) begin
        r_stab_cnt <= r_stab_cnt + c_CNT_W'(1);
      end
      if (w_same && (r_stab_cnt == c_CNT_MAX)) begin
        r_code <= r_sync;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_key_event.sv
// ----------------------------------------------------------------------------
// ps2_key_event : PS/2 held-key code to one-cycle key-event pulses.
// Auto-repeat is built only when KEY_AUTOREPEAT_EN is defined.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ps2_key_event
  import ps2_key_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_code,
  output logic       o_up,
  output logic       o_down,
  output logic       o_left,
  output logic       o_right,
  output logic       o_enter,
  output logic       o_space,
  output key_t       o_held
);

  generate
    if (STABLE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
      $error("ps2_key_event: cycle parameters must be >= 1");
    end
  endgenerate

  logic [7:0] w_acc_code;
  key_t       w_key;
  state_t     r_state;
  key_t       r_key;
  logic [5:0] r_pulse;

`ifdef KEY_AUTOREPEAT_EN
  localparam int                 c_TMR_MAX   = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int                 c_TMR_W     = $clog2(c_TMR_MAX + 1);
  localparam logic [c_TMR_W-1:0] c_HOLD_LOAD = c_TMR_W'(HOLD_CYCLES - 1);
  localparam logic [c_TMR_W-1:0] c_REP_LOAD  = c_TMR_W'(REPEAT_CYCLES - 1);

  logic [c_TMR_W-1:0] r_timer;
  logic               r_due;
`endif

  ps2_code_sync #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_code_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_code  (i_code),
    .o_code  (w_acc_code)
  );

  assign w_key  = decode_key(w_acc_code);
  assign o_held = r_key;
  assign {o_up, o_down, o_left, o_right, o_enter, o_space} = r_pulse;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_key   <= KEY_NONE;
      r_pulse <= '0;
`ifdef KEY_AUTOREPEAT_EN
      r_timer <= '0;
      r_due   <= 1'b0;
`endif
    end else begin
      r_pulse <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_key != KEY_NONE) begin
            r_key   <= w_key;
            r_state <= ST_PRESS;
          end
        end
        ST_PRESS: begin
          r_pulse <= key_onehot(r_key);
          r_state <= ST_HOLD;
`ifdef KEY_AUTOREPEAT_EN
          r_timer <= c_HOLD_LOAD;
          r_due   <= 1'b0;
`endif
        end
        default: begin
          // Release and key change are checked first so they always beat a due repeat.
          if (w_key == KEY_NONE) begin
            r_key   <= KEY_NONE;
            r_state <= ST_IDLE;
`ifdef KEY_AUTOREPEAT_EN
            r_timer <= '0;
            r_due   <= 1'b0;
`endif
          end else if (w_key != r_key) begin
            r_key   <= w_key;
            r_state <= ST_PRESS;
`ifdef KEY_AUTOREPEAT_EN
            r_due   <= 1'b0;
`endif
          end
`ifdef KEY_AUTOREPEAT_EN
          else if (r_due) begin
            r_pulse <= key_onehot(r_key);
            r_due   <= 1'b0;
          end else if (r_timer == '0) begin
            r_due   <= 1'b1;
            r_timer <= c_REP_LOAD;
            r_state <= ST_REPEAT;
          end else begin
            r_timer <= r_timer - c_TMR_W'(1);
          end
`endif
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/ps2_key_event.md
# ps2_key_event

Converts the held-key code produced by the PS/2 keyboard receiver (asynchronous to the system clock, 8-bit, 0 when no key held) into single-cycle, system-clock key-event pulses for the game logic. It synchronizes and glitch-filters the code, decodes the six supported keys, and emits one pulse per press. Optionally, it also emits auto-repeat pulses while a key stays held. It sits directly downstream of the keyboard receiver and upstream of the game controller FSM.

## Interface
- STABLE_CYCLES, 4: consecutive equal synchronized samples required before a code is accepted (≥1)
- HOLD_CYCLES, 25_000_000: held cycles after press pulse before first repeat (≥1)
- REPEAT_CYCLES, 5_000_000: cycles between repeat pulses (≥1)
- i_clk  in  1  system clock, all logic on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_code  in  8  held-key code from receiver, PS/2-clock domain, may change at any time
- o_up, o_down, o_left, o_right, o_enter, o_space  out  1 each  one-cycle event pulse
- o_held  out  3  key_t of accepted held key (KEY_NONE = 0)

## Operation
- Sync: i_code passes through 2-FF synchronizer (all 8 bits) → sync code.
- Filter: stab_cnt counts consecutive edges with sync code unchanged; resets to 0 on any change. When stab_cnt reaches STABLE_CYCLES-1 with value unchanged, the sync code becomes the accepted code.
- Decode: 8'h75 up, 8'h72 down, 8'h74 right, 8'h6b left, 8'h5a enter, 8'h29 space; any other value, including 8'h00 and 8'hf0, maps to KEY_NONE.
- FSM states: IDLE, PRESS, HOLD, REPEAT.
  - IDLE: accepted key ≠ NONE → PRESS.
  - PRESS, one cycle: pulse the key's output, load timer with HOLD_CYCLES-1 → HOLD.
  - HOLD: key NONE → IDLE; key changed to another valid key → PRESS (new key); timer 0 → pulse, load REPEAT_CYCLES-1 → REPEAT; else decrement.
  - REPEAT: same release/change rules; timer 0 → pulse, reload REPEAT_CYCLES-1; else decrement.
- At most one pulse output is high in any cycle. Pulses are registered outputs.
- o_held tracks the FSM's current key: NONE in IDLE.
- Timer width is $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)+1); the timer must not wrap below 0.

## Timing
- Reset: all pulses 0, o_held KEY_NONE, FSM IDLE, sync/filter regs 0, timer 0. Reset asserted mid-hold aborts immediately, with no pulse on release of reset unless the code is re-accepted through the full filter.
- Press latency with i_code stable before edge 1: sync valid after edge 2, accepted after edge 2+STABLE_CYCLES, PRESS entered at the next edge, and the pulse is high for exactly one cycle after edge 4+STABLE_CYCLES (edge 8 with default STABLE_CYCLES=4).
- First repeat pulse: HOLD_CYCLES+1 cycles after the press pulse. Later repeats: every REPEAT_CYCLES+1 cycles.
- Release and key change take effect with the same filter latency. A release accepted on the same edge that a timer expires wins: no pulse.
- A code glitch shorter than STABLE_CYCLES synchronized cycles is ignored.

## Configuration
- KEY_AUTOREPEAT_EN defined: HOLD and REPEAT behaviour exactly as above.
- Not defined: PRESS goes to HOLD with the timer unused and never expiring. There is exactly one pulse per press, and HOLD_CYCLES and REPEAT_CYCLES are ignored. Release and key-change rules are unchanged.

## Structure
- Package ps2_key_pkg holds:
  - the six scan-code localparams, plus 8'hf0 BREAK;
  - typedef enum logic [2:0] key_t {KEY_NONE, KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT, KEY_ENTER, KEY_SPACE};
  - the FSM state enum;
  - a decode function from scan code to key_t.
- One sub-module, ps2_code_sync: the 2-FF synchronizer plus stability filter, producing the accepted 8-bit code. FSM, timer and pulse outputs live in the top.

## Test plan
Benches use STABLE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=4 and macro defined unless stated.
- Hold i_code=8'h75 for 40 cycles, then 0: o_up pulses at edge 8, then at edges 19, 24, 29, 34, 39. No pulse after release is accepted. o_held=KEY_UP while held.
- Without KEY_AUTOREPEAT_EN, hold 8'h5a for 40 cycles: exactly one o_enter pulse, at edge 8.
- 8'h72 held, then switched directly to 8'h74 for 20 cycles: o_down pulses once, o_right pulses once at filter latency after the switch, and o_right's repeat timing restarts from the new press.
- 8'h6b present for only 3 cycles, or unsupported code 8'h1c held: no pulses, o_held stays KEY_NONE.
- 8'h29 held, i_rst_n pulsed low at edge 15: outputs clear asynchronously. After release of reset, o_space pulses again after full latency (4+STABLE_CYCLES edges).
- Release accepted on the same edge the repeat timer hits 0: no pulse that cycle, FSM returns to IDLE.
